ota_stim_dac: RTL and testbench

- Digital stimulus source for the on-chip OTA: the drive side that feeds the amplifier's analog input.
- Converts an 8-bit code, loaded from the dedicated inputs, into a first-order sigma-delta bitstream on a dedicated output.
- The bitstream is RC-filtered off-pad and returned to the OTA analog input pin.
- Optional hardware sweep steps the code 0→max so the OTA transfer curve can be captured without external sequencing.

---
 rtl/ota_stim_pkg.sv | 13 +
 rtl/ota_stim_edge_sync.sv | 27 ++
 rtl/ota_stim_dac.sv | 154 +++++++++++++++
 tb/tb_ota_stim_dac.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ota_stim_pkg.sv
// Shared types and constants for the OTA stimulus sigma-delta DAC.
package ota_stim_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int CODE_MAX    = (1 << DEF_WIDTH) - 1;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ota_stim_edge_sync.sv
// Pad strobe synchroniser (SYNC_STAGES flops) plus a history flop for rising-edge detect.
module ota_stim_edge_sync
    import ota_stim_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // A held level yields a single-cycle pulse.
    assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/ota_stim_dac.sv
// First-order sigma-delta stimulus DAC for the on-chip OTA.
// Define OTA_STIM_SWEEP_EN to build the hardware code sweep (FSM, dwell counter, busy/wrap).
module ota_stim_dac
    import ota_stim_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [WIDTH-1:0]   code_in,
    input  logic               load,
    input  logic               sweep_start,
    input  logic [DWELL_W-1:0] dwell,
    output logic               bs_out,
    output logic [WIDTH-1:0]   code_q,
    output logic               sweep_busy,
    output logic               sweep_wrap
);

    logic             load_edge;
    logic [WIDTH-1:0] acc_reg;
    logic             bs_reg;
    logic [WIDTH-1:0] code_reg;
    logic [WIDTH-1:0] code_next;
    logic [WIDTH:0]   sum;

    ota_stim_edge_sync u_load_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (load),
        .rise  (load_edge)
    );

    // Carry out of the accumulator is the bitstream; the remainder is kept, so the period is exact.
    assign sum = {1'b0, acc_reg} + {1'b0, code_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            bs_reg  <= 1'b0;
        end else if (ena) begin
            acc_reg <= sum[WIDTH-1:0];
            bs_reg  <= sum[WIDTH];
        end else begin
            bs_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_reg <= '0;
        end else if (ena) begin
            code_reg <= code_next;
        end
    end

`ifdef OTA_STIM_SWEEP_EN
    localparam logic [WIDTH-1:0] CODE_TOP = '1;

    logic               sweep_edge;
    sweep_state_t       state_reg;
    sweep_state_t       state_next;
    logic [DWELL_W-1:0] dwell_cnt_reg;
    logic [DWELL_W-1:0] dwell_cnt_next;
    logic               busy_reg;
    logic               busy_next;
    logic               wrap_reg;
    logic               wrap_next;

    ota_stim_edge_sync u_sweep_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (sweep_start),
        .rise  (sweep_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dwell_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
        end else if (ena) begin
            state_reg     <= state_next;
            dwell_cnt_reg <= dwell_cnt_next;
            busy_reg      <= busy_next;
            wrap_reg      <= wrap_next;
        end else begin
            wrap_reg      <= 1'b0;
        end
    end

    // A load edge has priority over everything, including a coincident sweep_start edge.
    always_comb begin
        state_next     = state_reg;
        dwell_cnt_next = dwell_cnt_reg;
        busy_next      = busy_reg;
        wrap_next      = 1'b0;
        code_next      = code_reg;
        if (load_edge) begin
            code_next  = code_in;
            state_next = IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sweep_edge) begin
                        code_next      = '0;
                        dwell_cnt_next = '0;
                        busy_next      = 1'b1;
                        state_next     = RUN;
                    end
                end
                RUN: begin
                    if (dwell_cnt_reg != dwell) begin
                        dwell_cnt_next = dwell_cnt_reg + 1'b1;
                    end else if (code_reg != CODE_TOP) begin
                        code_next      = code_reg + 1'b1;
                        dwell_cnt_next = '0;
                    end else begin
                        code_next      = '0;
                        wrap_next      = 1'b1;
                        busy_next      = 1'b0;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign sweep_busy = busy_reg;
    assign sweep_wrap = wrap_reg;
`else
    logic unused_sweep;
    assign unused_sweep = ^{sweep_start, dwell};

    always_comb begin
        code_next = code_reg;
        if (load_edge) begin
            code_next = code_in;
        end
    end

    assign sweep_busy = 1'b0;
    assign sweep_wrap = 1'b0;
`endif

    assign bs_out = bs_reg;
    assign code_q = code_reg;

endmodule

// File: tb/tb_ota_stim_dac.sv
// Self-checking bench for ota_stim_dac: behavioural model compared every cycle plus literal checks.
module tb_ota_stim_dac;

    localparam int WIDTH   = 8;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b0;
    logic [WIDTH-1:0]   code_in = '0;
    logic               load = 1'b0;
    logic               sweep_start = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic               bs_out;
    logic [WIDTH-1:0]   code_q;
    logic               sweep_busy;
    logic               sweep_wrap;

    ota_stim_dac #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .code_in     (code_in),
        .load        (load),
        .sweep_start (sweep_start),
        .dwell       (dwell),
        .bs_out      (bs_out),
        .code_q      (code_q),
        .sweep_busy  (sweep_busy),
        .sweep_wrap  (sweep_wrap)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: pad samples per clock, an edge is applied on the third clock after the rise.
    int m_acc, m_code, m_bs, m_busy, m_wrap, m_run, m_cnt, m_sum;
    bit lp1, lp2, lp3, sp1, sp2, sp3, m_lf, m_sf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_code = 0; m_bs = 0; m_busy = 0; m_wrap = 0; m_run = 0; m_cnt = 0;
            lp1 = 0; lp2 = 0; lp3 = 0; sp1 = 0; sp2 = 0; sp3 = 0;
        end else begin
            m_lf = lp2 & ~lp3;
            m_sf = sp2 & ~sp3;
            lp3 = lp2; lp2 = lp1; lp1 = load;
            sp3 = sp2; sp2 = sp1; sp1 = sweep_start;
            if (ena) begin
                m_sum  = m_acc + m_code;
                m_bs   = m_sum / 256;
                m_acc  = m_sum % 256;
                m_wrap = 0;
                if (m_lf) begin
                    m_code = int'(code_in);
                    m_run  = 0;
                    m_busy = 0;
                end
`ifdef OTA_STIM_SWEEP_EN
                else if (!m_run && m_sf) begin
                    m_code = 0; m_cnt = 0; m_run = 1; m_busy = 1;
                end else if (m_run) begin
                    if (m_cnt != int'(dwell)) m_cnt++;
                    else if (m_code < 255) begin m_code++; m_cnt = 0; end
                    else begin m_code = 0; m_wrap = 1; m_run = 0; m_busy = 0; end
                end
`endif
            end else begin
                m_bs   = 0;
                m_wrap = 0;
            end
        end
    end

    int total_ones  = 0;
    int total_wraps = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("bs_out", int'(bs_out), m_bs);
            check("code_q", int'(code_q), m_code);
            check("sweep_busy", int'(sweep_busy), m_busy);
            check("sweep_wrap", int'(sweep_wrap), m_wrap);
            total_ones  += int'(bs_out);
            total_wraps += int'(sweep_wrap);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [WIDTH-1:0] c);
        code_in = c;
        load    = 1'b1;
        step(4);
        load    = 1'b0;
        step(3);
    endtask

    int base, guard, r;
    logic [WIDTH-1:0] rc;

    initial begin
        // Reset state
        step(3);
        check("rst_bs", int'(bs_out), 0);
        check("rst_code", int'(code_q), 0);
        check("rst_busy", int'(sweep_busy), 0);
        check("rst_wrap", int'(sweep_wrap), 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Code 0: silent bitstream
        base = total_ones;
        step(512);
        check("zero_ones", total_ones - base, 0);

        // Load latency: applied on the third clock after the rise
        code_in = 8'h40;
        load    = 1'b1;
        step(2);
        check("lat_before", int'(code_q), 0);
        step(1);
        check("lat_third", int'(code_q), 8'h40);
        step(1);
        load = 1'b0;
        step(3);
        base = total_ones;
        step(256);
        check("ones_40", total_ones - base, 64);
        for (int k = 0; k < 8; k++) begin
            base = total_ones;
            step(4);
            check("period4", total_ones - base, 1);
        end

        // Full scale and ena hold
        do_load(8'hFF);
        base = total_ones;
        step(256);
        check("ones_ff", total_ones - base, 255);
        ena = 1'b0;
        step(1);
        base = total_ones;
        step(9);
        check("ena_off_ones", total_ones - base, 0);
        check("ena_off_code", int'(code_q), 8'hFF);
        ena = 1'b1;
        step(40);

        // Randomised loads, ena drops and (when built) short sweeps
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 4);
            rc = WIDTH'($urandom);
            case (r)
                0: do_load(rc);
                1: begin ena = 1'b0; do_load(rc); ena = 1'b1; step(2); end
                2: step($urandom_range(1, 20));
                3: begin ena = 1'b0; step($urandom_range(1, 5)); ena = 1'b1; end
                default: begin
                    dwell = DWELL_W'($urandom_range(0, 2));
                    sweep_start = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin code_in = rc; load = 1'b1; end
                    step($urandom_range(5, 40));
                    dwell = DWELL_W'($urandom_range(0, 2));
                    sweep_start = 1'b0;
                    load = 1'b0;
                    step($urandom_range(3, 30));
                    do_load(rc);
                end
            endcase
        end
        dwell = '0;
        step(5);

`ifdef OTA_STIM_SWEEP_EN
        // Full sweep with dwell=3
        dwell = 16'd3;
        sweep_start = 1'b1;
        step(3);
        check("sweep_busy_on", int'(sweep_busy), 1);
        check("sweep_code0", int'(code_q), 0);
        sweep_start = 1'b0;
        base = total_wraps;
        step(1000);
        check("sweep_busy_mid", int'(sweep_busy), 1);
        step(40);
        check("sweep_wrap_cnt", total_wraps - base, 1);
        check("sweep_end_code", int'(code_q), 0);
        check("sweep_end_busy", int'(sweep_busy), 0);

        // Abort by load, with a coincident sweep_start edge
        sweep_start = 1'b1;
        step(4);
        sweep_start = 1'b0;
        guard = 0;
        while (code_q != 8'h30 && guard < 400) begin
            step(1);
            guard++;
        end
        check("abort_reach_30", int'(guard < 400), 1);
        base = total_wraps;
        code_in = 8'hA5;
        load = 1'b1;
        sweep_start = 1'b1;
        step(3);
        check("abort_code", int'(code_q), 8'hA5);
        check("abort_busy", int'(sweep_busy), 0);
        step(2);
        load = 1'b0;
        sweep_start = 1'b0;
        step(40);
        check("abort_no_wrap", total_wraps - base, 0);
        check("abort_hold", int'(code_q), 8'hA5);

        // dwell=0 sweep with a live dwell change, then reset mid-sweep
        dwell = '0;
        sweep_start = 1'b1;
        step(40);
        dwell = 16'd1;
        sweep_start = 1'b0;
        step(60);
`else
        // Sweep not built: sweep_start must have no effect
        do_load(8'h5A);
        dwell = 16'd3;
        sweep_start = 1'b1;
        step(6);
        sweep_start = 1'b0;
        step(20);
        check("nosweep_code", int'(code_q), 8'h5A);
        check("nosweep_busy", int'(sweep_busy), 0);
        check("nosweep_wrap", int'(sweep_wrap), 0);
`endif

        // Asynchronous reset mid-activity
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_bs", int'(bs_out), 0);
        check("arst_code", int'(code_q), 0);
        check("arst_busy", int'(sweep_busy), 0);
        check("arst_wrap", int'(sweep_wrap), 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        do_load(8'h81);
        step(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
